// File: rtl/writeback_unit_if.sv
// Write-back stage bus: upstream instruction fields, memory response, flush,
// and register-file write port plus retired-instruction count.
//   slave  : the write-back unit (consumes in_*/mem_*/flush, drives wb_*, in_ready, retire_count)
//   master : whoever drives the stage (pipeline or testbench)
interface writeback_unit_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_we;
  logic [1:0]            in_wb_sel;
  logic [DATA_W-1:0]     in_alu;
  logic [DATA_W-1:0]     in_link;
  logic [1:0]            in_ld_size;
  logic                  in_ld_signed;
  logic [OFF_W-1:0]      in_byte_off;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  flush;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;
  logic [CNT_W-1:0]      retire_count;

  modport slave (
    input  in_valid, in_rd, in_reg_we, in_wb_sel, in_alu, in_link, in_ld_size,
           in_ld_signed, in_byte_off, mem_rvalid, mem_rdata, flush,
    output in_ready, wb_we, wb_rd, wb_data, retire_count
  );

  modport master (
    output in_valid, in_rd, in_reg_we, in_wb_sel, in_alu, in_link, in_ld_size,
           in_ld_signed, in_byte_off, mem_rvalid, mem_rdata, flush,
    input  in_ready, wb_we, wb_rd, wb_data, retire_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Write-back stage of the pipelined MIPS core.
// Selects ALU / load / link result, formats big-endian sub-word loads, waits
// for a variable-latency memory response, supports flush and counts retirements.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : writeback_unit_if.slave (instruction in, memory response, flush,
//           register-file write port, retire_count)
module writeback_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input logic             clk,
  input logic             reset,
  writeback_unit_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);

  localparam logic [1:0] SelAlu  = 2'd0;
  localparam logic [1:0] SelMem  = 2'd1;
  localparam logic [1:0] SelLink = 2'd2;
  localparam logic [1:0] SelNone = 2'd3;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_we_q, reg_we_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Load formatting. The selected field is shifted to the top of the word,
  // then shifted back down logically or arithmetically to extend it.
  // ---------------------------------------------------------------------------
  logic [1:0]               fmt_size;
  logic                     fmt_signed;
  logic [OFF_W-1:0]         fmt_off;
  logic [OFF_W-1:0]         sh;
  logic [6:0]               rsh;
  logic [DATA_W-1:0]        top;
  logic signed [DATA_W-1:0] top_s;
  logic signed [DATA_W-1:0] sext;
  logic [DATA_W-1:0]        zext;
  logic [DATA_W-1:0]        fmt_data;

  always_comb begin
    // In WAIT the latched fields describe the load, not the live inputs.
    fmt_size   = (state_q == StWait) ? size_q   : bus.in_ld_size;
    fmt_signed = (state_q == StWait) ? signed_q : bus.in_ld_signed;
    fmt_off    = (state_q == StWait) ? off_q    : bus.in_byte_off;
    sh         = '0;
    rsh        = '0;
    case (fmt_size)
      2'd0: begin
        sh  = fmt_off;
        rsh = 7'(DATA_W - 8);
      end
      2'd1: begin
        sh  = {fmt_off[OFF_W-1:1], 1'b0};
        rsh = 7'(DATA_W - 16);
      end
      2'd2: begin
        // Word inside a doubleword: offset bit 2 picks the half, 0 = upper.
        if (DATA_W == 64) begin
          sh  = {fmt_off[OFF_W-1], {(OFF_W-1){1'b0}}};
          rsh = 7'(DATA_W - 32);
        end
      end
      default: begin
        // Doubleword (or word-sized at DATA_W=32): whole word, no shift.
      end
    endcase
    top      = bus.mem_rdata << {sh, 3'b000};
    top_s    = top;
    sext     = top_s >>> rsh;
    zext     = top >> rsh;
    fmt_data = fmt_signed ? sext : zext;
  end

  // ---------------------------------------------------------------------------
  // Next-state and write-port logic
  // ---------------------------------------------------------------------------
  logic accept;
  assign accept = bus.in_valid && (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    reg_we_d  = reg_we_q;
    size_d    = size_q;
    signed_d  = signed_q;
    off_d     = off_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept && !bus.flush) begin
          if (bus.in_wb_sel != SelMem) begin
            wb_we_d = bus.in_reg_we && (bus.in_rd != '0) && (bus.in_wb_sel != SelNone);
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (wb_we_d) begin
              wb_rd_d   = bus.in_rd;
              wb_data_d = (bus.in_wb_sel == SelLink) ? bus.in_link : bus.in_alu;
            end
          end else if (bus.mem_rvalid) begin
            wb_we_d = bus.in_reg_we && (bus.in_rd != '0);
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (wb_we_d) begin
              wb_rd_d   = bus.in_rd;
              wb_data_d = fmt_data;
            end
          end else begin
            rd_d     = bus.in_rd;
            reg_we_d = bus.in_reg_we;
            size_d   = bus.in_ld_size;
            signed_d = bus.in_ld_signed;
            off_d    = bus.in_byte_off;
            state_d  = StWait;
          end
        end
      end
      StWait: begin
        // Flush wins over a response arriving in the same cycle.
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.mem_rvalid) begin
          wb_we_d = reg_we_q && (rd_q != '0);
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (wb_we_d) begin
            wb_rd_d   = rd_q;
            wb_data_d = fmt_data;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      reg_we_q  <= 1'b0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      off_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      reg_we_q  <= reg_we_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      off_q     <= off_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
    end
  end

  // in_ready depends on state only.
  assign bus.in_ready     = (state_q == StIdle);
  assign bus.wb_we        = wb_we_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.retire_count = cnt_q;

endmodule
